dbus_loader: RTL and testbench
==============================

// Module: dbus_loader
// PURPOSE
//  Producer side of the datapath D bus: fetches an operand from the 32-bit memory port and presents it on D[63:0].
//  Microprogram issues a load; block runs one (mode32) or two (64-bit) read beats, assembles, holds D stable.
//  Sits between the memory interface and the ALU/status slices, which consume D.
// PARAMETERS
//  AW       20   memory word-address width
//  TIMEOUT  15   max cycles waiting for mem_ack per beat before abort (1..255)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  nRESET     in   1   asynchronous active-low reset
//  ld_req     in   1   load request from microprogram; sampled only in IDLE
//  ld_addr    in   AW  word address of operand (low word)
//  ld_mode32  in   1   1: single 32-bit beat; 0: two beats, 64-bit operand
//  busy       out  1   load in progress (ld_req ignored)
//  done       out  1   one-cycle pulse: D updated with new operand
//  err        out  1   one-cycle pulse: load aborted (timeout / parity)
//  mem_req    out  1   memory read request, held until mem_ack
//  mem_addr   out  AW  memory read address, stable while mem_req
//  mem_ack    in   1   memory returns mem_rdata this cycle
//  mem_rdata  in   32  read data, valid with mem_ack
//  mem_par    in   4   per-byte odd parity of mem_rdata (used only with DBUS_PARITY_EN)
//  D          out  64  operand to datapath D bus; holds last value between loads
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, err=0, mem_req=0, mem_addr=0, D=0, timer=0.
//  States: IDLE -> RD_LO -> (RD_HI if !mode32) -> DONE -> IDLE; any abort -> ERR -> IDLE.
//  IDLE: ld_req=1 latches addr/mode32, next cycle RD_LO with mem_req=1, mem_addr=ld_addr, busy=1.
//  RD_LO: on mem_ack capture mem_rdata into lo; mode32 -> DONE, else -> RD_HI with mem_addr=ld_addr+1
//   (mod 2^AW, wrap from all-ones to 0). mem_req deasserted for one cycle between beats.
//  RD_HI: on mem_ack capture into hi -> DONE.
//  DONE: D <= mode32 ? {32'h0, lo} : {hi, lo}; done=1 for that cycle; busy=0 from next cycle.
//   D changes only in DONE; never mid-load, never on abort.
//  Handshake: mem_req/mem_addr constant until mem_ack; mem_ack while mem_req=0 is ignored.
//  Timer: cleared on entry to RD_LO/RD_HI, +1 per cycle without ack; reaching TIMEOUT -> ERR:
//   mem_req=0, err=1 one cycle, D unchanged, then IDLE. Ack in same cycle as timeout wins (no error).
//  ld_req while busy: ignored, not queued. ld_req in DONE/ERR cycle: ignored; accepted from IDLE.
//  Minimum latency, ack in first request cycle: mode32 done 3 cycles after ld_req; 64-bit 5 cycles.
//  Asynchronous reset mid-load: immediate IDLE, mem_req drops, D=0, pending beat discarded.
// CONFIGURATION
//  DBUS_PARITY_EN defined: each accepted beat checks ^{mem_rdata[8i+7:8i], mem_par[i]}==1 for i=0..3;
//   any failure -> ERR (err pulse, D unchanged, no second beat issued).
//  DBUS_PARITY_EN undefined: mem_par ignored, no parity logic, parity never causes ERR.
// STRUCTURE
//  Shared package: state enum (IDLE, RD_LO, RD_HI, DONE, ERR), DBUS_W=64, MEM_W=32 constants.
//  One sub-module: dbus_parity (4-byte odd-parity checker, 32+4 in, 1-bit ok out), instantiated only
//   under DBUS_PARITY_EN. FSM, timer, address incrementer and operand registers stay in top.
// TESTING
//  mode32 load addr=0x00010, ack 1st cycle, rdata=0xDEADBEEF -> done at +3, D=0x00000000_DEADBEEF.
//  64-bit load addr=0xFFFFF, beats 0x11111111 then 0x22222222 -> 2nd mem_addr=0x00000, D=0x22222222_11111111.
//  ack withheld 15 cycles -> err pulse, mem_req low, D keeps previous value, busy clears, next load works.
//  ld_req pulsed while busy and during DONE -> ignored; exactly one mem_req sequence observed.
//  nRESET asserted during RD_HI -> mem_req=0, busy=0, D=0 immediately; late mem_ack ignored.
//  DBUS_PARITY_EN: 1st beat with bad mem_par[2] -> err, no RD_HI request; without macro -> normal done.

Source files
------------

// File: rtl/dbus_loader_pkg.sv
// Shared types and constants for the D-bus operand loader.
// The parity helper is used only when DBUS_PARITY_EN is defined.
package dbus_loader_pkg;

  localparam int unsigned DBUS_W = 64;
  localparam int unsigned MEM_W  = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // Odd parity holds when the byte plus its parity bit carry an odd number of ones.
  function automatic logic byte_odd_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/dbus_loader_parity.sv
// dbus_parity: per-byte odd-parity check of one 32-bit memory beat.
// Instantiated by dbus_loader only when DBUS_PARITY_EN is defined.
module dbus_parity
  import dbus_loader_pkg::*;
(
  input  logic [MEM_W-1:0] data_i,
  input  logic [3:0]       par_i,
  output logic             ok_o
);

  // All four byte lanes must pass for the beat to be usable.
  always_comb begin
    ok_o = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ok_o = ok_o & byte_odd_ok(data_i[8*i +: 8], par_i[i]);
    end
  end

endmodule

// File: rtl/dbus_loader.sv
// dbus_loader: fetches a 32- or 64-bit operand over the 32-bit memory port and holds it on D.
// Optional per-beat parity checking is enabled with the DBUS_PARITY_EN macro.
module dbus_loader
  import dbus_loader_pkg::*;
#(
  parameter int unsigned AW      = 20,
  parameter int unsigned TIMEOUT = 15
)
(
  input  logic              clk,
  input  logic              nRESET,
  input  logic              ld_req,
  input  logic [AW-1:0]     ld_addr,
  input  logic              ld_mode32,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  input  logic              mem_ack,
  input  logic [MEM_W-1:0]  mem_rdata,
  input  logic [3:0]        mem_par,
  output logic [DBUS_W-1:0] D
);

  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               mode32_q, mode32_d;
  logic [MEM_W-1:0]   lo_q, lo_d;
  logic [MEM_W-1:0]   hi_q, hi_d;
  logic [7:0]         timer_q, timer_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               mem_req_q, mem_req_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DBUS_W-1:0]  d_q, d_d;
  logic               ack_s;
  logic               beat_ok_s;

`ifdef DBUS_PARITY_EN
  dbus_parity u_parity (
    .data_i (mem_rdata),
    .par_i  (mem_par),
    .ok_o   (beat_ok_s)
  );
`else
  logic par_unused_s;
  assign par_unused_s = ^mem_par;
  assign beat_ok_s    = 1'b1;
`endif

  // An acknowledge only counts while a request is actually outstanding.
  assign ack_s = mem_ack & mem_req_q;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mode32_d   = mode32_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    timer_d    = timer_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    d_d        = d_q;

    case (state_q)
      IDLE: begin
        if (ld_req) begin
          state_d    = RD_LO;
          addr_d     = ld_addr;
          mode32_d   = ld_mode32;
          mem_req_d  = 1'b1;
          mem_addr_d = ld_addr;
          busy_d     = 1'b1;
          timer_d    = 8'd0;
        end else begin
          busy_d = 1'b0;
        end
      end

      RD_LO: begin
        if (ack_s) begin
          mem_req_d = 1'b0;
          if (!beat_ok_s) begin
            state_d = ERR;
          end else begin
            lo_d = mem_rdata;
            if (mode32_q) begin
              state_d = DONE;
            end else begin
              state_d    = RD_HI;
              mem_addr_d = addr_q + ADDR_ONE;
            end
          end
        end else if (timer_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          state_d   = ERR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      // The first RD_HI cycle is the idle gap between beats; the request rises after it.
      RD_HI: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
          timer_d   = 8'd0;
        end else if (ack_s) begin
          mem_req_d = 1'b0;
          if (!beat_ok_s) begin
            state_d = ERR;
          end else begin
            hi_d    = mem_rdata;
            state_d = DONE;
          end
        end else if (timer_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          state_d   = ERR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      DONE: begin
        d_d     = mode32_q ? {32'h0000_0000, lo_q} : {hi_q, lo_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
        timer_d   = 8'd0;
      end
    endcase
  end

  // All sequencer state and outputs, cleared immediately by nRESET.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mode32_q   <= 1'b0;
      lo_q       <= 32'h0000_0000;
      hi_q       <= 32'h0000_0000;
      timer_q    <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      d_q        <= 64'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mode32_q   <= mode32_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      d_q        <= d_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign D        = d_q;

endmodule

// File: tb/tb_dbus_loader.sv
// Directed bench for dbus_loader; define DBUS_PARITY_EN to exercise the parity build.
module tb_dbus_loader;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          nRESET;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic          ld_mode32;
  logic          busy, done, err, mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [3:0]    mem_par;
  logic [63:0]   D;

  int total = 0;
  int bad   = 0;

  dbus_loader #(.AW(AW), .TIMEOUT(15)) dut (
    .clk       (clk),
    .nRESET    (nRESET),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_mode32 (ld_mode32),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_par   (mem_par),
    .D         (D)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] odd_par(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ~(^d[8*i +: 8]);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    mem_par   = odd_par(d);
  endtask

  task automatic no_beat();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    mem_par   = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRESET = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_mode32 = 1'b0;
    no_beat();
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 20'h0);
    chk("rst_D", D, 64'h0);
    nRESET = 1'b1;
    tick();

    // mode32 load, ack in first request cycle
    ld_req = 1'b1; ld_addr = 20'h00010; ld_mode32 = 1'b1;
    tick();
    ld_req = 1'b0;
    chk("m32_req", mem_req, 1'b1);
    chk("m32_addr", mem_addr, 20'h00010);
    chk("m32_busy", busy, 1'b1);
    beat(32'hDEADBEEF);
    tick();
    no_beat();
    chk("m32_req_drop", mem_req, 1'b0);
    chk("m32_D_early", D, 64'h0);
    tick();
    chk("m32_done", done, 1'b1);
    chk("m32_D", D, 64'h00000000_DEADBEEF);
    chk("m32_busy_clr", busy, 1'b0);
    tick();
    chk("m32_done_pulse", done, 1'b0);

    // 64-bit load with address wrap and a stray ack in the gap
    ld_req = 1'b1; ld_addr = 20'hFFFFF; ld_mode32 = 1'b0;
    tick();
    ld_req = 1'b0;
    chk("w64_addr_lo", mem_addr, 20'hFFFFF);
    beat(32'h11111111);
    tick();
    chk("w64_gap_req", mem_req, 1'b0);
    chk("w64_gap_busy", busy, 1'b1);
    beat(32'h99999999);
    tick();
    chk("w64_req_hi", mem_req, 1'b1);
    chk("w64_addr_hi", mem_addr, 20'h00000);
    beat(32'h22222222);
    tick();
    no_beat();
    chk("w64_D_hold", D, 64'h00000000_DEADBEEF);
    chk("w64_done_early", done, 1'b0);
    tick();
    chk("w64_done", done, 1'b1);
    chk("w64_D", D, 64'h22222222_11111111);
    tick();

    // Timeout: ack withheld for 15 request cycles
    ld_req = 1'b1; ld_addr = 20'h00200; ld_mode32 = 1'b0;
    tick();
    ld_req = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("tmo_req_last", mem_req, 1'b1);
    tick();
    chk("tmo_req_drop", mem_req, 1'b0);
    chk("tmo_err_early", err, 1'b0);
    tick();
    chk("tmo_err", err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_D", D, 64'h22222222_11111111);
    chk("tmo_done", done, 1'b0);
    tick();
    chk("tmo_err_pulse", err, 1'b0);

    // Ack on the last allowed cycle wins over the timeout
    ld_req = 1'b1; ld_addr = 20'h00300; ld_mode32 = 1'b1;
    tick();
    ld_req = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    beat(32'hCAFEF00D);
    tick();
    no_beat();
    tick();
    chk("edge_err", err, 1'b0);
    chk("edge_done", done, 1'b1);
    chk("edge_D", D, 64'h00000000_CAFEF00D);
    tick();

    // ld_req held while busy and through DONE is ignored
    ld_req = 1'b1; ld_addr = 20'h00040; ld_mode32 = 1'b1;
    tick();
    ld_addr = 20'h00080;
    chk("ign_addr", mem_addr, 20'h00040);
    beat(32'h12345678);
    tick();
    no_beat();
    chk("ign_req_done", mem_req, 1'b0);
    tick();
    ld_req = 1'b0;
    chk("ign_done", done, 1'b1);
    chk("ign_D", D, 64'h00000000_12345678);
    tick();
    chk("ign_no_req", mem_req, 1'b0);
    chk("ign_no_busy", busy, 1'b0);

    // Asynchronous reset during RD_HI
    ld_req = 1'b1; ld_addr = 20'h00100; ld_mode32 = 1'b0;
    tick();
    ld_req = 1'b0;
    beat(32'hAAAA0000);
    tick();
    no_beat();
    tick();
    chk("arst_req_hi", mem_req, 1'b1);
    nRESET = 1'b0;
    #1;
    chk("arst_req", mem_req, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_D", D, 64'h0);
    beat(32'h55555555);
    tick();
    nRESET = 1'b1;
    tick();
    no_beat();
    tick();
    chk("arst_late_req", mem_req, 1'b0);
    chk("arst_late_done", done, 1'b0);
    chk("arst_late_D", D, 64'h0);

    ld_req = 1'b1; ld_addr = 20'h00005; ld_mode32 = 1'b1;
    tick();
    ld_req = 1'b0;
    beat(32'h0BADF00D);
    tick();
    no_beat();
    tick();
    chk("post_rst_D", D, 64'h00000000_0BADF00D);

    // Parity: first beat with mem_par[2] flipped
    ld_req = 1'b1; ld_addr = 20'h00020; ld_mode32 = 1'b0;
    tick();
    ld_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h01020304; mem_par = 4'b0110;
    tick();
    no_beat();
    chk("par_req_gap", mem_req, 1'b0);
`ifdef DBUS_PARITY_EN
    tick();
    chk("par_err", err, 1'b1);
    chk("par_D", D, 64'h00000000_0BADF00D);
    tick();
    chk("par_no_hi", mem_req, 1'b0);
    chk("par_busy", busy, 1'b0);
`else
    tick();
    chk("par_req_hi", mem_req, 1'b1);
    chk("par_addr_hi", mem_addr, 20'h00021);
    mem_ack = 1'b1; mem_rdata = 32'h05060708; mem_par = 4'b1100;
    tick();
    no_beat();
    tick();
    chk("par_err", err, 1'b0);
    chk("par_done", done, 1'b1);
    chk("par_D", D, 64'h05060708_01020304);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
